// File: rtl/mac_array_ctrl.sv
// Pass sequencer for the weight-stationary MAC array: issues kernel and activation
// SRAM reads and the west-edge instruction, delayed one cycle to line up with read data.
module mac_array_ctrl #(
    parameter int unsigned col    = 8,
    parameter int unsigned row    = 8,
    parameter int unsigned GAP    = 8,
    parameter int unsigned DRAIN  = 16,
    parameter int unsigned addr_w = 11,
    parameter int unsigned len_w  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [addr_w-1:0] k_base,
    input  logic [addr_w-1:0] a_base,
    input  logic [len_w-1:0]  act_len,
    output logic              sram_cen,
    output logic [addr_w-1:0] sram_addr,
    output logic [1:0]        inst_w,
    output logic              busy,
    output logic              done
);

    localparam int unsigned LEN_MAX = (1 << len_w) - 1;
    localparam int unsigned M1      = (col > GAP) ? col : GAP;
    localparam int unsigned M2      = (M1 > DRAIN) ? M1 : DRAIN;
    localparam int unsigned M3      = (M2 > LEN_MAX) ? M2 : LEN_MAX;
    localparam int unsigned CMAX    = (M3 > row) ? M3 : row;
    localparam int unsigned CNT_W   = $clog2(CMAX + 1);

    localparam logic [CNT_W-1:0] COL_LAST   = CNT_W'(col - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KLOAD,
        S_KGAP,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [addr_w-1:0]  k_base_q, k_base_d;
    logic [addr_w-1:0]  a_base_q, a_base_d;
    logic [len_w-1:0]   act_len_q, act_len_d;
    logic [addr_w-1:0]  addr_q, addr_d;
    logic [1:0]         inst_q, inst_d;

    logic [addr_w-1:0]  addr_cur;
    logic [CNT_W-1:0]   act_last;

    assign act_last = CNT_W'(act_len_q) - CNT_W'(1);

    // Address is live while reading; otherwise the last issued address is held.
    always_comb begin
        addr_cur = addr_q;
        case (state_q)
            S_KLOAD: addr_cur = k_base_q + addr_w'(cnt_q);
            S_EXEC:  addr_cur = a_base_q + addr_w'(cnt_q);
            default: addr_cur = addr_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        k_base_d  = k_base_q;
        a_base_d  = a_base_q;
        act_len_d = act_len_q;
        addr_d    = addr_cur;
        inst_d    = {state_q == S_EXEC, state_q == S_KLOAD};

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start && !abort) begin
                    k_base_d  = k_base;
                    a_base_d  = a_base;
                    act_len_d = act_len;
                    state_d   = S_KLOAD;
                end
            end
            S_KLOAD: begin
                if (cnt_q == COL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_KGAP;
                end
            end
            S_KGAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = (act_len_q == '0) ? S_DRAIN : S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == act_last) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every transition and kills the in-flight instruction.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            inst_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            k_base_q  <= '0;
            a_base_q  <= '0;
            act_len_q <= '0;
            addr_q    <= '0;
            inst_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_base_q  <= k_base_d;
            a_base_q  <= a_base_d;
            act_len_q <= act_len_d;
            addr_q    <= addr_d;
            inst_q    <= inst_d;
        end
    end

    assign sram_cen  = !((state_q == S_KLOAD) || (state_q == S_EXEC));
    assign sram_addr = addr_cur;
    assign inst_w    = inst_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl: per-cycle expected outputs are queued when a
// pass is launched and popped against the DUT at each negative clock edge.
module tb_mac_array_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [10:0] k_base;
    logic [10:0] a_base;
    logic [10:0] act_len;
    logic        sram_cen;
    logic [10:0] sram_addr;
    logic [1:0]  inst_w;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        cen;
        logic [10:0] addr;
        logic [1:0]  inst;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t sb[$];

    mac_array_ctrl #(
        .col    (8),
        .row    (8),
        .GAP    (8),
        .DRAIN  (16),
        .addr_w (11),
        .len_w  (11)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .k_base    (k_base),
        .a_base    (a_base),
        .act_len   (act_len),
        .sram_cen  (sram_cen),
        .sram_addr (sram_addr),
        .inst_w    (inst_w),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".cen"},  16'(sram_cen),  16'(e.cen));
        check({tag, ".addr"}, 16'(sram_addr), 16'(e.addr));
        check({tag, ".inst"}, 16'(inst_w),    16'(e.inst));
        check({tag, ".busy"}, 16'(busy),      16'(e.busy));
        check({tag, ".done"}, 16'(done),      16'(e.done));
    endtask

    // Expected outputs in cycle c of an uninterrupted pass (cycle 0 = first KLOAD).
    function automatic exp_t model(input logic [10:0] k, input logic [10:0] a,
                                   input int L, input int c);
        exp_t e;
        logic [10:0] hold;
        e.cen  = 1'b1;
        e.inst = 2'b00;
        e.busy = 1'b1;
        e.done = 1'b0;
        hold   = (L > 0) ? a + 11'(L - 1) : k + 11'd7;
        if (c < 8) begin
            e.cen  = 1'b0;
            e.addr = k + 11'(c);
            e.inst = (c == 0) ? 2'b00 : 2'b01;
        end else if (c < 16) begin
            e.addr = k + 11'd7;
            e.inst = (c == 8) ? 2'b01 : 2'b00;
        end else if (c < 16 + L) begin
            e.cen  = 1'b0;
            e.addr = a + 11'(c - 16);
            e.inst = (c == 16) ? 2'b00 : 2'b10;
        end else if (c <= 32 + L) begin
            e.addr = hold;
            e.inst = ((L > 0) && (c == 16 + L)) ? 2'b10 : 2'b00;
            e.done = (c == 32 + L);
        end else begin
            e.addr = hold;
            e.busy = 1'b0;
        end
        return e;
    endfunction

    task automatic run_pass(input string tag, input logic [10:0] k, input logic [10:0] a,
                            input int L, input bit glitch, input int abort_at,
                            input int rst_at);
        int   n;
        exp_t e;
        exp_t r;
        if (abort_at >= 0)    n = abort_at + 5;
        else if (rst_at >= 0) n = rst_at + 1;
        else                  n = 32 + L + 4;
        for (int c = 0; c < n; c++) begin
            if ((abort_at >= 0) && (c > abort_at)) begin
                e      = model(k, a, L, abort_at);
                e.cen  = 1'b1;
                e.inst = 2'b00;
                e.busy = 1'b0;
                e.done = 1'b0;
            end else begin
                e = model(k, a, L, c);
            end
            sb.push_back(e);
        end

        @(negedge clk);
        start   = 1'b1;
        k_base  = k;
        a_base  = a;
        act_len = 11'(L);
        @(posedge clk);
        #1;
        start   = 1'b0;
        k_base  = 11'h555;
        a_base  = 11'h2AA;
        act_len = 11'd3;

        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            e = sb.pop_front();
            check_outputs($sformatf("%s.c%0d", tag, c), e);
            start = glitch && ((c == 5) || (c == 40));
            abort = (c == abort_at);
            if (c == rst_at) begin
                #2;
                reset = 1'b0;
                #1;
                r = '{cen: 1'b1, addr: 11'h000, inst: 2'b00, busy: 1'b0, done: 1'b0};
                check_outputs({tag, ".async_rst"}, r);
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        exp_t idle;
        reset   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        k_base  = '0;
        a_base  = '0;
        act_len = '0;

        #1;
        idle = '{cen: 1'b1, addr: 11'h000, inst: 2'b00, busy: 1'b0, done: 1'b0};
        check_outputs("reset", idle);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_outputs("idle_after_reset", idle);

        // Basic pass: 8 kernel reads, gap, 36 activation reads, drain, done at 68.
        run_pass("t1", 11'h010, 11'h100, 36, 1'b0, -1, -1);
        // No activations: EXEC skipped, done at 32.
        run_pass("t2", 11'h020, 11'h200, 0, 1'b0, -1, -1);
        // Starts while busy are ignored.
        run_pass("t3", 11'h010, 11'h100, 36, 1'b1, -1, -1);
        // Abort in the fourth EXEC cycle, then a clean full pass.
        run_pass("t4a", 11'h030, 11'h300, 20, 1'b0, 19, -1);
        run_pass("t4b", 11'h040, 11'h400, 10, 1'b0, -1, -1);

        // start together with abort in IDLE leaves the block idle.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle.busy", 16'(busy), 16'd0);
        check("start_abort_idle.cen",  16'(sram_cen), 16'd1);
        @(negedge clk);
        check("start_abort_idle.busy2", 16'(busy), 16'd0);

        // Asynchronous reset in the fourth KLOAD cycle.
        run_pass("t5", 11'h050, 11'h500, 8, 1'b0, -1, 3);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outputs($sformatf("t5.post_rst%0d", i), idle);
        end

        // Activation addresses wrap past 0x7FF.
        run_pass("t6", 11'h060, 11'h7F0, 32, 1'b0, -1, -1);

        check("sb_empty", 16'(sb.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
